// File: rtl/fft_bitrev_reorder_if.sv
// Stream bundle around the FFT reorder buffer: a dual-lane bit-reversed input
// and a single-lane natural-order output, both valid/ready.
interface fft_bitrev_reorder_if #(
  parameter int W = 16
);
  logic                in_valid;
  logic                in_ready;
  logic                in_sof;
  logic signed [W-1:0] in_ar;
  logic signed [W-1:0] in_ai;
  logic signed [W-1:0] in_br;
  logic signed [W-1:0] in_bi;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] out_r;
  logic signed [W-1:0] out_i;
  logic                out_first;
  logic                out_last;

  modport master (
    output in_valid, in_sof, in_ar, in_ai, in_br, in_bi, out_ready,
    input  in_ready, out_valid, out_r, out_i, out_first, out_last
  );

  modport slave (
    input  in_valid, in_sof, in_ar, in_ai, in_br, in_bi, out_ready,
    output in_ready, out_valid, out_r, out_i, out_first, out_last
  );
endinterface

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: takes two bit-reversed complex bins per beat from the
// FFT and emits one bin per cycle in natural order under valid/ready backpressure.
module fft_bitrev_reorder #(
  parameter int N    = 8,
  parameter int LOGN = 3,
  parameter int W    = 16
) (
  input  logic                  c,
  input  logic                  rst,
  fft_bitrev_reorder_if.slave   bus,
  output logic [7:0]            drop_cnt
);
  localparam int HALF = N / 2;
  localparam int HW   = LOGN - 1;

  // Lane A always lands in the lower half of a frame (address MSB 0) and lane B in
  // the upper half, so each lane gets its own single-write-port memory.
  logic [2*W-1:0] mem_a [0:N-1];
  logic [2*W-1:0] mem_b [0:N-1];

  logic [1:0]          full_reg, full_next;
  logic                wbank_reg, rbank_reg;
  logic [HW-1:0]       wcnt_reg;
  logic [LOGN-1:0]     rcnt_reg;
  logic [7:0]          drop_reg;
  logic                out_valid_reg, out_first_reg, out_last_reg;
  logic signed [W-1:0] out_r_reg, out_i_reg;

  logic          accept, wdone, load, rdone;
  logic [HW-1:0] widx, wrev;
  logic [LOGN-1:0] waddr, raddr;

  assign bus.in_ready = !full_reg[wbank_reg];
  assign accept       = bus.in_valid && bus.in_ready;

  // A start-of-frame beat always restarts at beat 0, discarding any partial frame.
  assign widx  = bus.in_sof ? '0 : wcnt_reg;
  assign wdone = (widx == HW'(HALF - 1));

  genvar gi;
  generate
    for (gi = 0; gi < HW; gi++) begin : g_rev
      assign wrev[gi] = widx[HW-1-gi];
    end
  endgenerate

  assign waddr = {wbank_reg, wrev};
  assign raddr = {rbank_reg, rcnt_reg[HW-1:0]};
  assign load  = full_reg[rbank_reg] && (!bus.out_valid || bus.out_ready);
  assign rdone = (rcnt_reg == LOGN'(N - 1));

  always_ff @(posedge c) begin
    if (accept) begin
      mem_a[waddr] <= {bus.in_ar, bus.in_ai};
      mem_b[waddr] <= {bus.in_br, bus.in_bi};
    end
  end

  // Set and clear can never hit the same bank in one cycle: a set needs the
  // write bank empty, a clear needs the read bank full.
  always_comb begin
    full_next = full_reg;
    if (accept && wdone) full_next[wbank_reg] = 1'b1;
    if (load && rdone)   full_next[rbank_reg] = 1'b0;
  end

  always_ff @(posedge c) begin
    if (rst) begin
      full_reg      <= '0;
      wbank_reg     <= 1'b0;
      rbank_reg     <= 1'b0;
      wcnt_reg      <= '0;
      rcnt_reg      <= '0;
      drop_reg      <= '0;
      out_valid_reg <= 1'b0;
      out_first_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      out_r_reg     <= '0;
      out_i_reg     <= '0;
    end else begin
      full_reg <= full_next;
      if (accept) begin
        wcnt_reg <= wdone ? '0 : widx + HW'(1);
        if (wdone) wbank_reg <= ~wbank_reg;
        if (bus.in_sof && (wcnt_reg != '0) && (drop_reg != 8'hff))
          drop_reg <= drop_reg + 8'd1;
      end
      if (load) begin
        {out_r_reg, out_i_reg} <= rcnt_reg[LOGN-1] ? mem_b[raddr] : mem_a[raddr];
        out_valid_reg <= 1'b1;
        out_first_reg <= (rcnt_reg == '0);
        out_last_reg  <= rdone;
        rcnt_reg      <= rdone ? '0 : rcnt_reg + LOGN'(1);
        if (rdone) rbank_reg <= ~rbank_reg;
      end else if (bus.out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_first = out_first_reg;
  assign bus.out_last  = out_last_reg;
  assign bus.out_r     = out_r_reg;
  assign bus.out_i     = out_i_reg;
  assign drop_cnt      = drop_reg;
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for fft_bitrev_reorder (N=8): bit-reversed frames in, natural-order
// bins out, with backpressure, bank saturation, resync and reset corner cases.
module tb_fft_bitrev_reorder;
  localparam int N    = 8;
  localparam int LOGN = 3;
  localparam int W    = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] drop_cnt;

  fft_bitrev_reorder_if #(.W(W)) bus ();

  fft_bitrev_reorder #(.N(N), .LOGN(LOGN), .W(W)) dut (
    .c        (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  // Per beat: the two natural bins it carries, and the expected output values at
  // natural positions 2m and 2m+1 (real = index, imag = -index, before base offset).
  typedef struct {
    int bin_a; int bin_b;
    int exp_r0; int exp_i0; int exp_r1; int exp_i1;
  } vec_t;
  vec_t tbl [4];

  typedef struct {
    logic signed [W-1:0] r;
    logic signed [W-1:0] i;
    logic first;
    logic last;
    int   cyc;
  } obs_t;
  obs_t got [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_mode = 1;
  int acc_cyc = 0;
  int acc0 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready: 0 = stalled, 1 = always ready, 2 = repeating 1,0,0,1.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b0;
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      endcase
    end
  end

  // Output monitor: logs every handshake and checks that a stalled bin holds.
  logic prev_stall = 1'b0;
  obs_t prev;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!(bus.out_valid && bus.out_r == prev.r && bus.out_i == prev.i &&
              bus.out_first == prev.first && bus.out_last == prev.last)) begin
          errors++;
          $display("FAIL stall_hold actual v=%0b r=%0d i=%0d required v=1 r=%0d i=%0d",
                   bus.out_valid, bus.out_r, bus.out_i, prev.r, prev.i);
        end
      end
      prev = '{bus.out_r, bus.out_i, bus.out_first, bus.out_last, cyc};
      prev_stall = bus.out_valid && !bus.out_ready;
      if (bus.out_valid && bus.out_ready) begin
        got.push_back(prev);
        $display("OUT  cyc=%0d r=%0d i=%0d first=%0b last=%0b",
                 cyc, bus.out_r, bus.out_i, bus.out_first, bus.out_last);
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic drive_beat(input int base, input int m, input bit sof);
    bus.in_valid = 1'b1;
    bus.in_sof   = sof;
    bus.in_ar    = W'(tbl[m].bin_a + base);
    bus.in_ai    = W'(-(tbl[m].bin_a + base));
    bus.in_br    = W'(tbl[m].bin_b + base);
    bus.in_bi    = W'(-(tbl[m].bin_b + base));
  endtask

  task automatic send_beat(input int base, input int m, input bit sof);
    bit ok = 1'b0;
    drive_beat(base, m, sof);
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        acc_cyc = cyc;
        $display("BEAT cyc=%0d base=%0d m=%0d sof=%0b", cyc, base, m, sof);
      end
      @(posedge clk);
      #1;
      if (ok) break;
    end
    chk("beat_accept_timeout", longint'(ok), 1);
  endtask

  task automatic send_frame(input int base, input bit sof);
    for (int m = 0; m < 4; m++) send_beat(base, m, (m == 0) ? sof : 1'b0);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic wait_out(input int n);
    for (int t = 0; t < 600 && got.size() < n; t++) @(posedge clk);
    chk("drain_timeout", longint'(got.size() >= n), 1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_got(input int nfr, input int b0, input int step);
    chk("out_count", got.size(), nfr * 8);
    for (int f = 0; f < nfr; f++) begin
      for (int p = 0; p < 8; p++) begin
        int k = f * 8 + p;
        int b = b0 + f * step;
        int m = p / 2;
        int er = ((p % 2) ? tbl[m].exp_r1 : tbl[m].exp_r0) + b;
        int ei = ((p % 2) ? tbl[m].exp_i1 : tbl[m].exp_i0) - b;
        if (k < got.size()) begin
          chk("out_r", got[k].r, er);
          chk("out_i", got[k].i, ei);
          chk("out_first_last", {got[k].first, got[k].last}, {p == 0, p == 7});
        end
      end
    end
  endtask

  initial begin
    tbl[0] = '{0, 4, 0,  0, 1, -1};
    tbl[1] = '{2, 6, 2, -2, 3, -3};
    tbl[2] = '{1, 5, 4, -4, 5, -5};
    tbl[3] = '{3, 7, 6, -6, 7, -7};
    bus.in_valid = 1'b0; bus.in_sof = 1'b0;
    bus.in_ar = '0; bus.in_ai = '0; bus.in_br = '0; bus.in_bi = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_out_r", bus.out_r, 0);
    rst = 1'b0;

    // Single frame with first-output latency
    rdy_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    send_frame(0, 1'b1);
    idle();
    chk("latency_not_yet", bus.out_valid, 0);
    @(posedge clk);
    #1;
    chk("latency_valid", bus.out_valid, 1);
    chk("latency_first", bus.out_first, 1);
    wait_out(8);
    check_got(1, 0, 0);

    // Backpressure 1,0,0,1 during drain
    got.delete();
    rdy_mode = 2;
    send_frame(16, 1'b1);
    idle();
    wait_out(8);
    check_got(1, 16, 0);

    // Both banks full, third frame stalls until frame 1 bin 7 is consumed
    got.delete();
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    send_frame(32, 1'b1);
    send_frame(48, 1'b1);
    drive_beat(64, 0, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    chk("sat_in_ready", bus.in_ready, 0);
    chk("sat_out_valid", bus.out_valid, 1);
    chk("sat_hold_r", bus.out_r, 32);
    rdy_mode = 1;
    send_beat(64, 0, 1'b1);
    acc0 = acc_cyc;
    for (int m = 1; m < 4; m++) send_beat(64, m, 1'b0);
    idle();
    wait_out(24);
    check_got(3, 32, 16);
    if (got.size() > 7) chk("sat_release_cycle", acc0, got[7].cyc);

    // Sustained streaming; last frame starts without in_sof
    got.delete();
    send_frame(80, 1'b1);
    send_frame(96, 1'b1);
    send_frame(112, 1'b1);
    send_frame(128, 1'b0);
    idle();
    wait_out(32);
    check_got(4, 80, 16);
    if (got.size() >= 32) chk("stream_span", got[31].cyc - got[0].cyc, 31);
    chk("stream_drop_cnt", drop_cnt, 0);

    // Resync: two-beat partial frame discarded by a new in_sof
    got.delete();
    send_beat(144, 0, 1'b1);
    send_beat(144, 1, 1'b0);
    send_frame(160, 1'b1);
    idle();
    wait_out(8);
    chk("resync_drop_cnt", drop_cnt, 1);
    check_got(1, 160, 0);

    // Reset while bin 3 is on the output
    got.delete();
    send_frame(176, 1'b1);
    idle();
    begin
      bit seen = 1'b0;
      for (int t = 0; t < 100 && !seen; t++) begin
        @(negedge clk);
        if (bus.out_valid && bus.out_r == 179) seen = 1'b1;
      end
      chk("reset_bin3_seen", longint'(seen), 1);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_drop_cnt", drop_cnt, 0);
    rst = 1'b0;
    got.delete();
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_no_partial", got.size(), 0);
    send_frame(192, 1'b1);
    idle();
    wait_out(8);
    check_got(1, 192, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fft_bitrev_reorder.md
Name: fft_bitrev_reorder

Overview:
- Consumer at the output end of the dual-lane pipelined FFT. Accepts two complex bins per beat in bit-reversed order.
- Stores each frame in a ping-pong buffer and emits one complex bin per cycle in natural order (bin 0..N-1).
- Downstream handshake is valid/ready, so spectrum post-processing can apply backpressure.

Parameters:
- N, 8, FFT points per frame; power of 2, N >= 4.
- LOGN, 3, log2(N); must match N.
- W, 16, bit width of each real/imag component, signed two's complement.

Ports:
- c  in  1  clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  block can accept a beat.
- in_sof  in  1  beat is beat 0 of a frame.
- in_ar, in_ai  in  W each  lane A real/imag.
- in_br, in_bi  in  W each  lane B real/imag.
- out_valid  out  1  output bin present.
- out_ready  in  1  downstream accepts the bin.
- out_r, out_i  out  W each  output bin real/imag.
- out_first  out  1  high with bin 0.
- out_last  out  1  high with bin N-1.
- drop_cnt  out  8  count of partial frames discarded; saturates at 255.

Behaviour:
- Frame format: N/2 beats per frame. Beat m (0..N/2-1) carries natural bin bitrev(2m) on lane A and bitrev(2m+1) on lane B. bitrev reverses LOGN bits.
- Beat accepted when in_valid && in_ready.
- Buffer: two banks (0, 1), each N complex entries, plus per-bank full flags. The write bank pointer and read bank pointer both start at bank 0.
- Write side:
  - An accepted beat writes lane A at address bitrev(2*wcnt) and lane B at address bitrev(2*wcnt+1) of the write bank. wcnt then increments.
  - On the beat with wcnt = N/2-1: set full[wbank], toggle wbank, set wcnt to 0.
  - in_ready = !full[wbank], combinational from registered state.
- in_sof handling:
  - Accepted beat with in_sof=1 and wcnt != 0: discard the partial frame, drop_cnt++, then write this beat as beat 0. wcnt becomes 1.
  - in_sof=1 with wcnt = 0: normal.
  - in_sof=0 with wcnt = 0: accepted as beat 0; no error.
- Read side:
  - The output register loads when full[rbank] && (!out_valid || out_ready). It loads entry rcnt of the read bank and sets out_valid=1, out_first=(rcnt==0), out_last=(rcnt==N-1). rcnt then increments.
  - On loading rcnt = N-1: clear full[rbank], toggle rbank, set rcnt to 0.
  - If out_valid && out_ready and no new load occurs, clear out_valid.
  - While out_valid && !out_ready, out_r, out_i, out_first and out_last hold stable.
- Latency: the frame-completing beat accepted at edge k gives out_valid=1 with bin 0 after edge k+1, provided the read side is idle. After that, one bin per cycle while out_ready=1.
- Throughput:
  - Input peak is 2 bins/cycle and output is 1 bin/cycle.
  - in_ready drops only when both banks are full.
  - The next frame starts on the cycle after the previous out_last is consumed, with no bubble.
- Simultaneous events:
  - Bank-full set by the write side and bank-full clear by the read side on different banks in the same cycle: both take effect.
  - A bank released on cycle t may be written from cycle t+1.
- Reset: all full flags, pointers, wcnt, rcnt and drop_cnt go to 0. out_valid, out_first and out_last go to 0. out_r and out_i go to 0. in_ready=1 the cycle after reset.
- Reset mid-frame or mid-drain discards all buffered data; no partial output follows.
- Arithmetic: none; data passes through bit-exact, with no scaling.

Test Plan:
- Single frame, N=8. Beats give bins (0,4), (2,6), (1,5), (3,7); each bin's real part equals its index and its imag part equals minus the index. out_ready=1 -> 8 consecutive outputs with real parts 0..7 and imag parts 0..-7. out_first is on bin 0, out_last on bin 7. First out_valid arrives 1 cycle after the 4th beat.
- Backpressure: toggle out_ready 1,0,0,1 repeatedly during the drain -> no bin lost or duplicated; data stable while stalled; order still 0..7.
- Bank saturation: hold out_ready=0 and send 3 frames back-to-back -> frames 1 and 2 accepted (8 beats). in_ready=0 from then on. The 3rd frame's first beat stalls until bin 7 of frame 1 is consumed. All 3 frames are later output in order.
- Sustained streaming: 4 frames with in_valid continuously high and out_ready=1 -> 32 contiguous outputs with no gaps after the first, and correct per-frame values.
- Resync: send 2 beats, then a beat with in_sof=1, then a full frame -> drop_cnt=1, and only the complete frame is output, correctly ordered.
- Reset mid-drain: assert rst during bin 3 of the output -> next cycle out_valid=0, in_ready=1, drop_cnt=0. A new frame after reset outputs correctly.
